// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter and its round-robin picker:
// FSM state encoding, requester indices and default timing limits.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_DMEM   = 1;
    localparam int REQ_DMA    = 2;

    localparam int DEF_NREQ      = 3;
    localparam int DEF_TIMEOUT   = 200;
    localparam int DEF_MAX_RETRY = 3;

    // Index/counter width that never collapses to zero bits for tiny ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after rr_ptr,
// wrapping modulo NREQ. Also used by the DMA channel scheduler.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = idx_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    logic [NREQ-1:0] shifted_s;
    logic            hit_s;
    int              cand_s;

    // Scan from farthest to nearest so the closest candidate after rr_ptr wins.
    always_comb begin
        valid     = 1'b0;
        idx       = rr_ptr;
        shifted_s = {NREQ{1'b0}};
        hit_s     = 1'b0;
        cand_s    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_s    = (int'(rr_ptr) + k) % NREQ;
            shifted_s = req >> cand_s;
            hit_s     = shifted_s[0];
            valid     = valid | hit_s;
            idx       = hit_s ? PTR_W'(cand_s) : idx;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the address interpreter's single ren/wen request port among NREQ
// requesters with round-robin grant, full ack/release handshake and timeout retry.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*32-1:0]   addr,
    input  logic [NREQ*32-1:0]   wdata,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic [31:0]          rdata,
    output logic                 mem_ren,
    output logic                 mem_wen,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_data_i,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_data_o
);

    localparam int PTR_W   = idx_width(NREQ);
    localparam int TIMER_W = $clog2(TIMEOUT) + 1;
    localparam int RETRY_W = idx_width(MAX_RETRY + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
    localparam logic [PTR_W-1:0]   PTR_RESET  = PTR_W'(NREQ - 1);

    arb_state_e         state_r;
    logic [PTR_W-1:0]   gnt_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [TIMER_W-1:0] timer_r;
    logic [RETRY_W-1:0] retry_r;
    logic               we_r;

    logic               pick_valid_s;
    logic [PTR_W-1:0]   pick_idx_s;
    logic [31:0]        pick_addr_s;
    logic [31:0]        pick_wdata_s;
    logic               pick_we_s;
    logic [NREQ-1:0]    gnt_onehot_s;
    logic               timeout_s;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .valid  (pick_valid_s),
        .idx    (pick_idx_s)
    );

    // Route the winning requester's fields to the issue registers (AND-OR mux).
    always_comb begin
        pick_addr_s  = 32'd0;
        pick_wdata_s = 32'd0;
        pick_we_s    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pick_addr_s  = pick_addr_s  | (addr[i*32 +: 32]  & {32{pick_idx_s == PTR_W'(i)}});
            pick_wdata_s = pick_wdata_s | (wdata[i*32 +: 32] & {32{pick_idx_s == PTR_W'(i)}});
            pick_we_s    = pick_we_s    | (we[i] & (pick_idx_s == PTR_W'(i)));
        end
    end

    // Per-transaction decode of the granted requester and the timeout limit.
    always_comb begin
        gnt_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_r;
        timeout_s    = (timer_r == TIMER_LAST);
    end

    // Arbitration FSM with registered memory-port and requester-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= {PTR_W{1'b0}};
            rr_ptr_r   <= PTR_RESET;
            timer_r    <= {TIMER_W{1'b0}};
            retry_r    <= {RETRY_W{1'b0}};
            we_r       <= 1'b0;
            ack        <= {NREQ{1'b0}};
            err        <= {NREQ{1'b0}};
            rdata      <= 32'd0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= 32'd0;
            mem_data_i <= 32'd0;
        end else begin
            ack <= {NREQ{1'b0}};
            err <= {NREQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        gnt_r      <= pick_idx_s;
                        we_r       <= pick_we_s;
                        mem_addr   <= pick_addr_s;
                        mem_data_i <= pick_wdata_s;
                        mem_ren    <= ~pick_we_s;
                        mem_wen    <= pick_we_s;
                        timer_r    <= {TIMER_W{1'b0}};
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        rdata    <= mem_data_o;
                        ack      <= gnt_onehot_s;
                        mem_ren  <= 1'b0;
                        mem_wen  <= 1'b0;
                        rr_ptr_r <= gnt_r;
                        timer_r  <= {TIMER_W{1'b0}};
                        retry_r  <= {RETRY_W{1'b0}};
                        state_r  <= ST_RELEASE;
                    end else if (timeout_s) begin
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                        timer_r <= {TIMER_W{1'b0}};
                        // Last allowed attempt expired: give up and report.
                        if (retry_r == RETRY_LAST) begin
                            err      <= gnt_onehot_s;
                            rr_ptr_r <= gnt_r;
                            retry_r  <= {RETRY_W{1'b0}};
                            state_r  <= ST_RELEASE;
                        end else begin
                            retry_r <= retry_r + RETRY_W'(1);
                            state_r <= ST_BACKOFF;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                ST_BACKOFF: begin
                    mem_ren <= ~we_r;
                    mem_wen <= we_r;
                    state_r <= ST_ISSUE;
                end
                ST_RELEASE: begin
                    if (!mem_ack) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an interpreter responder model and
// an in-order scoreboard of expected grants, issues and completions.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ      = 3;
    localparam int TIMEOUT   = 8;
    localparam int MAX_RETRY = 3;
    localparam logic [31:0] RD_KEY = 32'h5EAD_BEFF;

    typedef struct {
        logic [1:0]  idx;
        bit          is_err;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [31:0]          a_addr  [NREQ];
    logic [31:0]          a_wdata [NREQ];
    logic [NREQ*32-1:0]   addr_bus;
    logic [NREQ*32-1:0]   wdata_bus;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      err;
    logic [31:0]          rdata;
    logic                 mem_ren;
    logic                 mem_wen;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_data_i;
    logic                 mem_ack;
    logic [31:0]          mem_data_o;

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   resp_lat  = 2;
    int   skip_left = 0;
    exp_t sb_q [$];

    initial forever #5 clk = ~clk;

    always_comb begin
        addr_bus  = '0;
        wdata_bus = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_bus[i*32 +: 32]  = a_addr[i];
            wdata_bus[i*32 +: 32] = a_wdata[i];
        end
    end

    mem_port_arbiter #(
        .NREQ      (NREQ),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr       (addr_bus),
        .wdata      (wdata_bus),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_data_i (mem_data_i),
        .mem_ack    (mem_ack),
        .mem_data_o (mem_data_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] idx, input bit is_err);
        exp_t e;
        e.idx    = idx;
        e.is_err = is_err;
        e.is_wr  = we[idx];
        e.addr   = a_addr[idx];
        e.wdata  = a_wdata[idx];
        e.rd     = a_addr[idx] ^ RD_KEY;
        sb_q.push_back(e);
    endtask

    task automatic drain(input int budget, input bit drop, input string tag);
        for (int k = 0; k < budget && sb_q.size() != 0; k++) begin
            @(negedge clk);
            if (drop) req = req & ~(ack | err);
        end
        if (!drop) req = '0;
        check(tag, 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Interpreter model: acks resp_lat cycles after ren/wen rise, holds ack until both fall.
    initial begin : interp
        int cnt;
        bit prev_act;
        bit ignoring;
        cnt = 0; prev_act = 1'b0; ignoring = 1'b0;
        mem_ack = 1'b0; mem_data_o = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                if (!mem_ren && !mem_wen) mem_ack = 1'b0;
            end else if (mem_ren || mem_wen) begin
                if (!prev_act) begin
                    cnt = 0;
                    if (skip_left > 0) begin skip_left--; ignoring = 1'b1; end
                    else ignoring = 1'b0;
                end
                if (!ignoring && resp_lat > 0) begin
                    cnt++;
                    if (cnt >= resp_lat) begin
                        mem_ack    = 1'b1;
                        mem_data_o = mem_addr ^ RD_KEY;
                    end
                end
            end
            prev_act = mem_ren || mem_wen;
        end
    end

    // Scoreboard: issue fields and completion pulses are checked against the queue head.
    initial begin : monitor
        exp_t       e;
        logic [2:0] oh;
        bit         prev_issue;
        prev_issue = 1'b0;
        forever begin
            @(negedge clk);
            if ((mem_ren || mem_wen) && !prev_issue && sb_q.size() != 0) begin
                e = sb_q[0];
                check("issue_excl", 32'(mem_ren & mem_wen), 32'd0);
                check("issue_wen", 32'(mem_wen), 32'(e.is_wr));
                check("issue_addr", mem_addr, e.addr);
                if (e.is_wr) check("issue_wdata", mem_data_i, e.wdata);
            end
            prev_issue = mem_ren || mem_wen;
            if (ack != 3'b000 || err != 3'b000) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 32'({ack, err}), 32'd0);
                end else begin
                    e  = sb_q.pop_front();
                    oh = 3'b001 << e.idx;
                    check("resp_ack", 32'(ack), e.is_err ? 32'd0 : 32'(oh));
                    check("resp_err", 32'(err), e.is_err ? 32'(oh) : 32'd0);
                    if (!e.is_err && !e.is_wr) check("resp_rdata", rdata, e.rd);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        int ren_cnt;
        int bad;
        int err_at;
        int rises;
        bit ack_seen;
        bit prev_ren;
        bit exp_ren;

        rst_n = 1'b0; req = '0; we = '0;
        for (int i = 0; i < NREQ; i++) begin a_addr[i] = 32'd0; a_wdata[i] = 32'd0; end
        repeat (3) @(negedge clk);
        check("rst_mem_ren", 32'(mem_ren), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data_i", mem_data_i, 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single dmem read acked 3 cycles after mem_ren.
        resp_lat = 3;
        a_addr[REQ_DMEM] = 32'h8000_0010;
        push(2'(REQ_DMEM), 1'b0);
        req = 3'b010;
        @(negedge clk);
        check("t1_ren_latency", 32'(mem_ren), 32'd1);
        k = 0;
        while (ack[REQ_DMEM] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        req = '0;
        check("t1_ack_latency", 32'(k), 32'd3);
        check("t1_rdata", rdata, 32'hDEAD_BEEF);
        check("t1_ren_dropped", 32'(mem_ren), 32'd0);
        @(negedge clk);
        check("t1_ack_pulse", 32'(ack), 32'd0);
        check("t1_rdata_held", rdata, 32'hDEAD_BEEF);
        check("t1_ren_release", 32'(mem_ren), 32'd0);
        drain(20, 1'b1, "t1_drain");

        // All three requesting continuously from reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resp_lat = 2;
        a_addr[0] = 32'h0000_1000; a_addr[1] = 32'h8000_0020; a_addr[2] = 32'h1F80_0100;
        for (int r = 0; r < 2; r++) begin
            push(2'd0, 1'b0); push(2'd1, 1'b0); push(2'd2, 1'b0);
        end
        req = 3'b111;
        drain(200, 1'b0, "t2_drain");

        // DMA write.
        a_addr[REQ_DMA] = 32'h1F80_0004; a_wdata[REQ_DMA] = 32'h1234_5678;
        we = 3'b100;
        push(2'(REQ_DMA), 1'b0);
        req = 3'b100;
        @(negedge clk);
        check("t3_wen", 32'(mem_wen), 32'd1);
        check("t3_addr", mem_addr, 32'h1F80_0004);
        check("t3_data_i", mem_data_i, 32'h1234_5678);
        ren_cnt = int'(mem_ren);
        k = 0;
        while (sb_q.size() != 0 && k < 40) begin
            @(negedge clk); k++;
            req = req & ~(ack | err);
            ren_cnt += int'(mem_ren);
        end
        check("t3_no_ren", 32'(ren_cnt), 32'd0);
        check("t3_queue", 32'(sb_q.size()), 32'd0);
        we = '0;
        repeat (3) @(negedge clk);

        // Interpreter never acks: four 8-cycle windows, then err.
        resp_lat = 0;
        a_addr[0] = 32'h0000_2000;
        push(2'd0, 1'b1);
        req = 3'b001;
        bad = 0; err_at = 0; rises = 0; ack_seen = 1'b0; prev_ren = 1'b0;
        for (int s = 1; s <= 40; s++) begin
            @(negedge clk);
            exp_ren = (s <= 35) && (s % 9 != 0);
            if (mem_ren !== exp_ren) bad++;
            if (mem_ren && !prev_ren) rises++;
            prev_ren = mem_ren;
            if (ack[0]) ack_seen = 1'b1;
            if (err[0]) begin err_at = s; req[0] = 1'b0; end
        end
        check("t4_ren_pattern", 32'(bad), 32'd0);
        check("t4_windows", 32'(rises), 32'd4);
        check("t4_err_cycle", 32'(err_at), 32'd36);
        check("t4_no_ack", 32'(ack_seen), 32'd0);
        check("t4_queue", 32'(sb_q.size()), 32'd0);

        // Pointer advanced past 0 after the error: 1 is served before 0.
        resp_lat = 2;
        a_addr[0] = 32'h0000_2100; a_addr[1] = 32'h8000_0030;
        push(2'd1, 1'b0); push(2'd0, 1'b0);
        req = 3'b011;
        drain(100, 1'b1, "t5_drain");

        // Ack on the second attempt, then on the fourth (retry count was cleared).
        a_addr[0] = 32'h0000_3000;
        skip_left = 1;
        push(2'd0, 1'b0);
        req = 3'b001;
        drain(100, 1'b1, "t6_drain");
        a_addr[0] = 32'h0000_3004;
        skip_left = 3;
        push(2'd0, 1'b0);
        req = 3'b001;
        drain(150, 1'b1, "t6b_drain");

        // Reset while mem_ack is pending abandons the transaction.
        resp_lat = 3;
        a_addr[1] = 32'h8000_0040;
        push(2'd1, 1'b0);
        req = 3'b010;
        k = 0;
        while (mem_ack !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
        check("t7_ack_pending", 32'(mem_ack), 32'd1);
        rst_n = 1'b0;
        sb_q.delete();
        req = '0;
        @(negedge clk);
        check("t7_ack", 32'(ack), 32'd0);
        check("t7_err", 32'(err), 32'd0);
        check("t7_ren", 32'(mem_ren), 32'd0);
        check("t7_wen", 32'(mem_wen), 32'd0);
        check("t7_addr", mem_addr, 32'd0);
        check("t7_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        a_addr[0] = 32'h0000_4000; a_addr[1] = 32'h8000_0050; a_addr[2] = 32'h1F80_0200;
        push(2'd0, 1'b0); push(2'd1, 1'b0); push(2'd2, 1'b0);
        req = 3'b111;
        drain(200, 1'b1, "t7_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory-request port of the address interpreter (ren/wen/addr/data_i, with ack held until ren/wen fall) among NREQ requesters: CPU instruction fetch, CPU data and DMA.
- Round-robin grant; registered issue of the winner's request downstream.
- Runs the full ack/release handshake.
- Retries timed-out transactions; reports an error after MAX_RETRY failures.
- Sits between the CPU/DMA front ends and the address interpreter.

Parameters:
NREQ, 3, number of requesters (index 0 = ifetch, 1 = dmem, 2 = DMA)
TIMEOUT, 200, cycles in ISSUE without mem_ack before a retry is triggered
MAX_RETRY, 3, retries before err is returned (total attempts = MAX_RETRY+1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req  in  NREQ  per-requester request; held with its fields stable until ack or err
we  in  NREQ  per-requester 1 = write, 0 = read
addr  in  NREQ*32  packed request addresses; requester i at [32i+31:32i]
wdata  in  NREQ*32  packed write data
ack  out  NREQ  one-cycle completion pulse to the granted requester
err  out  NREQ  one-cycle failure pulse to the granted requester
rdata  out  32  read data, valid while ack is high, then held
mem_ren  out  1  to the interpreter ren
mem_wen  out  1  to the interpreter wen
mem_addr  out  32  to the interpreter addr
mem_data_i  out  32  to the interpreter data_i
mem_ack  in  1  interpreter ack; high until ren and wen are both low
mem_data_o  in  32  interpreter read data, valid while mem_ack is high

Behaviour:
- Reset (rst_n low at a clk edge), outputs and state:
  - all outputs 0; state IDLE
  - rr_ptr = NREQ-1, so requester 0 wins first
  - timer and retry count 0
  - reset mid-transaction abandons it with no ack or err; the interpreter recovers through its own WAIT/IDLE path once ren/wen are 0.
- Datapath registers: mem_* outputs are registered. mem_ren and mem_wen are never high together.
- IDLE:
  - If any req is set, grant the first set bit searching from rr_ptr+1 upward (mod NREQ).
  - Latch that requester's addr, wdata and we into mem_addr and mem_data_i; set mem_ren = ~we or mem_wen = we; set gnt = index.
  - Go to ISSUE. Latency from req to mem_ren/mem_wen is 1 cycle.
- ISSUE: hold all mem_* outputs; increment the timer every cycle.
  - mem_ack = 1: register rdata <= mem_data_o, pulse ack[gnt], drop mem_ren/mem_wen, set rr_ptr <= gnt, clear timer and retry count, go to RELEASE.
  - timer == TIMEOUT-1 and retry < MAX_RETRY: drop mem_ren/mem_wen, retry++, timer = 0, go to BACKOFF.
  - timer == TIMEOUT-1 and retry == MAX_RETRY: pulse err[gnt], drop mem_ren/mem_wen, rr_ptr <= gnt, clear counters, go to RELEASE.
- BACKOFF: hold mem_ren/mem_wen low for exactly 1 cycle, then reassert the same request and go to ISSUE. The latched request is reused; req is not re-sampled.
- RELEASE: mem_ren/mem_wen stay 0. Stay until mem_ack == 0, then go to IDLE. No new grant while mem_ack is high.
- Requester-side boundaries:
  - A requester that drops req before ack is a protocol violation; the transaction still completes and the ack pulse is harmless.
  - A requester may raise req again in the cycle after its ack. It is then served behind the other pending requesters because rr_ptr has advanced.
- Width rules: timer is clog2(TIMEOUT)+1 bits; retry count is clog2(MAX_RETRY+1) bits; no wrap is possible because both are cleared at their limits.
- Minimum transaction: IDLE→ISSUE (1) + interpreter latency + RELEASE (≥1) + return to IDLE.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, ISSUE, BACKOFF, RELEASE)
  - requester index constants (REQ_IFETCH = 0, REQ_DMEM = 1, REQ_DMA = 2)
  - default TIMEOUT/MAX_RETRY constants
- One natural sub-module, rr_pick: combinational round-robin selector taking req[NREQ] and rr_ptr, returning a valid flag and the granted index. It is reusable by the DMA channel scheduler.

Test Plan:
- Single read, requester 1 (dmem): addr 0x8000_0010, interpreter acks 3 cycles after mem_ren with mem_data_o 0xDEAD_BEEF → mem_ren 1 cycle after req; ack[1] one-cycle pulse; rdata 0xDEAD_BEEF; mem_ren low until mem_ack falls.
- All three requesting continuously from reset, each acked after 2 cycles → grant order 0,1,2,0,1,2; never two acks in one cycle; mem_ren/mem_wen never both high.
- Write, requester 2 (DMA): addr 0x1F80_0004, wdata 0x1234_5678 → mem_wen=1 with mem_addr/mem_data_i matching; ack[2] after mem_ack; mem_ren stays 0.
- Interpreter never acks, TIMEOUT=8, MAX_RETRY=3 → 4 issue windows of 8 cycles, each separated by a 1-cycle low on mem_ren; then err[0] pulse with ack[0]=0; rr_ptr advances.
- Acks on the second attempt (mem_ack 2 cycles into the retry) → ack pulse with correct rdata and no err; retry count back to 0 for the next transaction.
- rst_n low during ISSUE with mem_ack pending → next cycle all outputs 0; no ack/err; after release, requester 0 is granted first.
